time_set_ctrl: RTL

User time-setting controller that sits directly upstream of the BCD time-of-day counter. It turns debounced button pulses into the counter's `clk_mode` and `time_in` controls. It freezes the running time, lets the user edit hours, minutes and seconds with BCD wrap-around, then commits the edited value with a load request held across one 1 Hz edge. It also drives field-select and blink hints for the display stage.

---
 rtl/time_set_ctrl_if.sv | 23 ++
 rtl/time_set_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// Button, tick and time bus between the user-input front end, the time-set
// controller and the BCD time-of-day counter.
interface time_set_ctrl_if;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    logic        btn_dec;
    logic [23:0] time_now;
    logic [1:0]  clk_mode;
    logic [23:0] time_set;
    logic [1:0]  field_sel;
    logic        blink;

    modport master (
        output tick_1hz, btn_mode, btn_inc, btn_dec, time_now,
        input  clk_mode, time_set, field_sel, blink
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc, btn_dec, time_now,
        output clk_mode, time_set, field_sel, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-setting controller: freezes the counter, edits hh/mm/ss in BCD and
// commits the result with a load request that spans a 1 Hz edge.
module time_set_ctrl #(
    parameter int BLINK_DIV = 25_000_000,
    parameter int TIMEOUT_S = 30
) (
    input logic            clk,
    input logic            rst,
    time_set_ctrl_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_S + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_S - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        S_RUN, S_EDIT_HR, S_EDIT_MIN, S_EDIT_SEC, S_COMMIT
    } state_e;

    state_e        state_q, state_d;
    logic [23:0]   time_set_q, time_set_d;
    logic [1:0]    clk_mode_q, clk_mode_d;
    logic [1:0]    field_sel_q, field_sel_d;
    logic          blink_q, blink_d;
    logic          tick_seen_q, tick_seen_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          accepted;

    function automatic logic [7:0] step_field(input logic [7:0] v,
                                              input logic [7:0] max,
                                              input logic       up);
        logic [7:0] r;
        if (up) begin
            if (v == max)          r = 8'h00;
            else if (v[3:0] == 9)  r = {v[7:4] + 4'd1, 4'h0};
            else                   r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == 8'h00)        r = max;
            else if (v[3:0] == 0)  r = {v[7:4] - 4'd1, 4'h9};
            else                   r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // A corrupt snapshot from the counter must never reach time_set.
    function automatic logic [7:0] sanitize(input logic [7:0] v,
                                            input logic [7:0] max);
        return (v[7:4] <= 4'd9 && v[3:0] <= 4'd9 && v <= max) ? v : 8'h00;
    endfunction

    always_comb begin
        state_d     = state_q;
        time_set_d  = time_set_q;
        tmo_d       = tmo_q;
        tick_seen_d = 1'b0;
        accepted    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (bus.btn_mode) begin
                    state_d    = S_EDIT_HR;
                    accepted   = 1'b1;
                    tmo_d      = '0;
                    time_set_d = {sanitize(bus.time_now[23:16], 8'h23),
                                  sanitize(bus.time_now[15:8],  8'h59),
                                  sanitize(bus.time_now[7:0],   8'h59)};
                end
            end
            S_EDIT_HR, S_EDIT_MIN, S_EDIT_SEC: begin
                if (bus.btn_mode) begin
                    accepted = 1'b1;
                    tmo_d    = '0;
                    state_d  = (state_q == S_EDIT_HR)  ? S_EDIT_MIN :
                               (state_q == S_EDIT_MIN) ? S_EDIT_SEC : S_COMMIT;
                end else if (bus.btn_inc ^ bus.btn_dec) begin
                    accepted = 1'b1;
                    tmo_d    = '0;
                    if (state_q == S_EDIT_HR)
                        time_set_d[23:16] = step_field(time_set_q[23:16], 8'h23, bus.btn_inc);
                    else if (state_q == S_EDIT_MIN)
                        time_set_d[15:8] = step_field(time_set_q[15:8], 8'h59, bus.btn_inc);
                    else
                        time_set_d[7:0] = step_field(time_set_q[7:0], 8'h59, bus.btn_inc);
                end else if (bus.tick_1hz) begin
                    if (tmo_q == TMO_LAST) begin
                        state_d = S_RUN;
                        tmo_d   = '0;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            S_COMMIT: begin
                // Leave one cycle after the first tick so the load spans a 1 Hz edge.
                if (tick_seen_q) state_d = S_RUN;
                else             tick_seen_d = bus.tick_1hz;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        blink_d     = blink_q;
        bcnt_d      = bcnt_q;
        clk_mode_d  = 2'b00;
        field_sel_d = 2'b00;
        if (state_d == S_RUN || state_d == S_COMMIT || accepted) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BLINK_LAST) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + BW'(1);
        end
        unique case (state_d)
            S_EDIT_HR:  begin clk_mode_d = 2'b10; field_sel_d = 2'b01; end
            S_EDIT_MIN: begin clk_mode_d = 2'b10; field_sel_d = 2'b10; end
            S_EDIT_SEC: begin clk_mode_d = 2'b10; field_sel_d = 2'b11; end
            S_COMMIT:   clk_mode_d = 2'b01;
            default:    clk_mode_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            time_set_q  <= 24'h000000;
            clk_mode_q  <= 2'b00;
            field_sel_q <= 2'b00;
            blink_q     <= 1'b1;
            tick_seen_q <= 1'b0;
            tmo_q       <= '0;
            bcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            time_set_q  <= time_set_d;
            clk_mode_q  <= clk_mode_d;
            field_sel_q <= field_sel_d;
            blink_q     <= blink_d;
            tick_seen_q <= tick_seen_d;
            tmo_q       <= tmo_d;
            bcnt_q      <= bcnt_d;
        end
    end

    assign bus.clk_mode  = clk_mode_q;
    assign bus.time_set  = time_set_q;
    assign bus.field_sel = field_sel_q;
    assign bus.blink     = blink_q;

endmodule
